// File: rtl/sqrt_arb_pkg.sv
// rtl/sqrt_arb_pkg.sv - shared constants and FSM state type for the SquareRoot arbiter
package sqrt_arb_pkg;
    localparam int DATA_W      = 18;
    localparam int DEF_TIMEOUT = 31;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SKIP,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// rtl/sqrt_arbiter_rr_pick.sv - combinational round-robin winner select starting at ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    logic [IDX_W:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // Scan farthest-first so the request nearest to ptr overwrites the others.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                idx   = cand[IDX_W-1:0];
                valid = 1'b1;
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin sharing of one SquareRoot unit among NUM_REQ requesters
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      sq_cs,
    output logic                      sq_we,
    output logic [DATA_W-1:0]         sq_di,
    input  logic [DATA_W-1:0]         sq_do,
    input  logic                      sq_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [1:0]         rst_sync;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [TMR_W-1:0]   timer;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [DATA_W-1:0]  pick_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_data = req_data[pick_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rst_sync   <= 2'b00;
            ptr        <= '0;
            gidx       <= '0;
            timer      <= '0;
            ack        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            sq_cs      <= 1'b0;
            sq_we      <= 1'b0;
            sq_di      <= '0;
        end else begin
            rst_sync   <= {rst_sync[0], 1'b1};
            ack        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            sq_cs      <= 1'b0;
            sq_we      <= 1'b0;
            sq_di      <= '0;
            // The FSM stays parked until the released reset has crossed both sync flops.
            if (rst_sync[1]) begin
                case (state)
                    IDLE: begin
                        if (pick_valid) begin
                            gidx  <= pick_idx;
                            ack   <= pick_grant;
                            sq_cs <= 1'b1;
                            sq_we <= 1'b1;
                            sq_di <= pick_data;
                            state <= ISSUE;
                        end
                    end
                    ISSUE: state <= SKIP;
                    SKIP: begin
                        timer <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (sq_done) begin
                            resp_valid <= NUM_REQ'(1) << gidx;
                            resp_data  <= sq_do;
                            state      <= RESP;
                        end else if (timer == TMR_W'(TIMEOUT)) begin
                            resp_valid <= NUM_REQ'(1) << gidx;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    RESP: begin
                        ptr   <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - directed and randomized self-checking bench for sqrt_arbiter
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;

    localparam int N = 4;
    localparam int T = 31;
    localparam int L = 9;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N*DATA_W-1:0]  req_data = '0;
    logic [N-1:0]         ack;
    logic [N-1:0]         resp_valid;
    logic [DATA_W-1:0]    resp_data;
    logic                 resp_err;
    logic                 sq_cs;
    logic                 sq_we;
    logic [DATA_W-1:0]    sq_di;
    logic [DATA_W-1:0]    sq_do = '0;
    logic                 sq_done = 1'b0;

    always #5 clk = ~clk;

    sqrt_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .sq_cs      (sq_cs),
        .sq_we      (sq_we),
        .sq_di      (sq_di),
        .sq_do      (sq_do),
        .sq_done    (sq_done)
    );

    int total = 0;
    int bad = 0;
    int model_ptr = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    logic [N-1:0] hold_mask = '0;
    bit stall = 0;
    bit stale = 0;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // SquareRoot unit emulation: DONE rises L cycles after the write edge and stays up.
    logic [DATA_W-1:0] pend = '0;
    int                cnt = 0;
    bit                stale_hold = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sq_cs && sq_we) begin
            pend       <= DATA_W'(isqrt(int'(sq_di)));
            cnt        <= stall ? 0 : L;
            stale_hold <= stale;
            if (!stale) sq_done <= 1'b0;
        end else begin
            if (stale_hold) begin
                stale_hold <= 0;
                sq_done    <= 1'b0;
            end
            if (cnt == 1) begin
                sq_done <= 1'b1;
                sq_do   <= pend;
            end
            if (cnt > 0) cnt <= cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int g, input int data);
        req_data[g*DATA_W +: DATA_W] = DATA_W'(data);
        req[g] = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_rv"}, 32'(resp_valid), 0);
        check({tag, "_rd"}, 32'(resp_data), 0);
        check({tag, "_re"}, 32'(resp_err), 0);
        check({tag, "_cs"}, 32'(sq_cs), 0);
        check({tag, "_we"}, 32'(sq_we), 0);
        check({tag, "_di"}, 32'(sq_di), 0);
    endtask

    task automatic serve(input int g, input int exp_res, input bit exp_err,
                         input int exp_delay, input int exp_gap, output int wait_ack);
        int n;
        int data;
        data = int'(req_data[g*DATA_W +: DATA_W]);
        n = 0;
        while (ack === '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        wait_ack = n;
        check("ack_onehot", 32'(ack), 32'(1 << g));
        check("issue_cs", 32'(sq_cs), 1);
        check("issue_we", 32'(sq_we), 1);
        check("issue_di", 32'(sq_di), 32'(data));
        check("issue_rv_quiet", 32'(resp_valid), 0);
        if (exp_gap > 0) check("ack_gap", 32'(cyc - last_ack_cyc), 32'(exp_gap));
        last_ack_cyc = cyc;
        if (!hold_mask[g]) req[g] = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(ack), 0);
        check("cs_pulse", 32'(sq_cs), 0);
        n = 1;
        while (resp_valid === '0 && n < 200) begin
            check("rd_zero", 32'(resp_data), 0);
            @(negedge clk);
            n++;
        end
        check("resp_delay", 32'(n), 32'(exp_delay));
        check("resp_onehot", 32'(resp_valid), 32'(1 << g));
        check("resp_data", 32'(resp_data), 32'(exp_res));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        model_ptr = (g + 1) % N;
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wa;
        int order[4];
        int res[4];
        int pulses;
        int n;
        logic [N-1:0] mask;
        int rdata[N];

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (3) @(negedge clk);

        // Single request on requester 0
        set_op(0, 10000);
        serve(0, 100, 0, L + 2, 0, wa);
        check("single_ack_lat", 32'(wa), 1);

        // All four at once from a fresh pointer
        do_reset();
        set_op(0, 0); set_op(1, 16); set_op(2, 2500); set_op(3, 250000);
        order = '{0, 1, 2, 3};
        res = '{0, 4, 50, 500};
        for (int k = 0; k < 4; k++) begin
            check("all4_order", 32'(pick(req, model_ptr)), 32'(order[k]));
            serve(order[k], res[k], 0, L + 2, (k > 0) ? L + 4 : 0, wa);
        end

        // Fairness: 2 holds REQ while 0 and 3 request; ptr first moved to 2
        set_op(1, 49);
        serve(1, 7, 0, L + 2, 0, wa);
        hold_mask = 4'b0100;
        set_op(0, 144); set_op(2, 81); set_op(3, 1);
        order = '{2, 3, 0, 2};
        res = '{9, 1, 12, 9};
        for (int k = 0; k < 4; k++) begin
            if (k == 3) hold_mask = '0;
            serve(order[k], res[k], 0, L + 2, 0, wa);
        end

        // Timeout with a stalled unit, then recovery
        stall = 1;
        set_op(1, 1000);
        serve(1, 0, 1, T + 3, 0, wa);
        stall = 0;
        set_op(1, 1000);
        serve(1, 31, 0, L + 2, 0, wa);

        // Stale DONE high through ISSUE and SKIP
        stale = 1;
        set_op(2, 90000);
        serve(2, 300, 0, L + 2, 0, wa);
        stale = 0;

        // Reset during ISSUE: registered outputs must clear asynchronously
        set_op(3, 5);
        n = 0;
        while (ack === '0 && n < 50) begin @(negedge clk); n++; end
        check("pre_rst_ack", 32'(ack), 32'(1 << 3));
        rst_n = 1'b0;
        req = '0;
        #1;
        check_idle_outputs("rst_issue");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (3) @(negedge clk);

        // Reset mid-WAIT: no response escapes, then a clean operation
        set_op(0, 40000);
        n = 0;
        while (ack === '0 && n < 50) begin @(negedge clk); n++; end
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid !== '0) pulses++;
        end
        check("rst_no_resp", 32'(pulses), 0);
        check("stale_done_up", 32'(sq_done), 1);
        rst_n = 1'b1;
        model_ptr = 0;
        set_op(0, 25000);
        serve(0, 158, 0, L + 2, 0, wa);
        check("post_rst_ack_lat", 32'(wa), 3);

        // Randomized request masks and operands against the round-robin model
        for (int r = 0; r < 12; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    rdata[i] = int'($urandom_range(0, (1 << DATA_W) - 1));
                    set_op(i, rdata[i]);
                end
            end
            while (req != '0) begin
                n = pick(req, model_ptr);
                serve(n, isqrt(rdata[n]), 0, L + 2, 0, wa);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
